bus_arbiter: RTL and testbench



---
 rtl/bus_pkg.sv | 42 ++++
 rtl/bus_rr_picker.sv | 32 +++
 rtl/bus_arbiter.sv | 120 ++++++++++++
 tb/tb_bus_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared system-bus definitions.
//   - Bus direction and strobe levels (READ/WRITE, ENABLE_/DISABLE_).
//   - Master index type and BUS_MASTER_0..7 constants.
//   - Idle values driven onto the shared bus when no master is granted.
//   - Arbiter state encoding.
//   - A modulo helper used by the round-robin picker.
package bus_pkg;

  // Direction and strobe levels. Strobes are active-low.
  localparam logic READ     = 1'b1;
  localparam logic WRITE    = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int BUS_MAX_MASTERS = 8;

  typedef logic [2:0] bus_master_idx_t;

  localparam bus_master_idx_t BUS_MASTER_0 = 3'd0;
  localparam bus_master_idx_t BUS_MASTER_1 = 3'd1;
  localparam bus_master_idx_t BUS_MASTER_2 = 3'd2;
  localparam bus_master_idx_t BUS_MASTER_3 = 3'd3;
  localparam bus_master_idx_t BUS_MASTER_4 = 3'd4;
  localparam bus_master_idx_t BUS_MASTER_5 = 3'd5;
  localparam bus_master_idx_t BUS_MASTER_6 = 3'd6;
  localparam bus_master_idx_t BUS_MASTER_7 = 3'd7;

  // Shared bus idle values. Address and write data idle at all-zero.
  localparam logic BUS_IDLE_AS_ = DISABLE_;
  localparam logic BUS_IDLE_RW  = READ;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_e;

  // Wraps a non-negative index into 0..n-1.
  function automatic int bus_wrap_idx(input int v, input int n);
    return v % n;
  endfunction

endpackage

// File: rtl/bus_rr_picker.sv
// Combinational round-robin picker.
// Scans an active-low request vector starting at start_i and wrapping
// modulo N, and reports the first asserted (low) request.
// Ports:
//   req_n_i  in  N   request vector, active-low
//   start_i  in  IW  first index to examine
//   found_o  out 1   a low request was found
//   index_o  out IW  index of that request (0 when none found)
module bus_rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_n_i,
  input  logic [IW-1:0] start_i,
  output logic          found_o,
  output logic [IW-1:0] index_o
);
  import bus_pkg::*;

  always_comb begin
    found_o = 1'b0;
    index_o = '0;
    // Offset 0 is checked first, so the lowest offset from start_i wins.
    for (int i = 0; i < N; i++) begin
      if (!found_o && !req_n_i[bus_wrap_idx(int'(start_i) + i, N)]) begin
        found_o = 1'b1;
        index_o = IW'(bus_wrap_idx(int'(start_i) + i, N));
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter and master-side shared-bus multiplexer.
// Grants the shared system bus to one master at a time. Grants are
// registered and active-low. The granted master's address, strobe,
// direction and write data are steered onto the shared bus.
// Ports:
//   clk        in  1               system clock
//   rst        in  1               asynchronous reset, active-low
//   m_req_     in  NUM_MASTERS     per-master request, active-low
//   m_grnt_    out NUM_MASTERS     per-master grant, active-low, registered
//   m_addr     in  NUM_MASTERS*ADDR_W  per-master address (master i at [i*ADDR_W +: ADDR_W])
//   m_as_      in  NUM_MASTERS     per-master address strobe, active-low
//   m_rw       in  NUM_MASTERS     per-master direction
//   m_wr_data  in  NUM_MASTERS*DATA_W  per-master write data
//   s_addr     out ADDR_W          shared bus address
//   s_as_      out 1               shared strobe, active-low
//   s_rw       out 1               shared direction
//   s_wr_data  out DATA_W          shared write data
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ARB_IDLE  | no master granted; owner_q parked on the last owner
// ARB_OWNED | master owner_q holds the bus until it releases its request
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W      = 30,
  parameter int DATA_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_MASTERS-1:0]        m_req_,
  output logic [NUM_MASTERS-1:0]        m_grnt_,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]        m_as_,
  input  logic [NUM_MASTERS-1:0]        m_rw,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wr_data,
  output logic [ADDR_W-1:0]             s_addr,
  output logic                          s_as_,
  output logic                          s_rw,
  output logic [DATA_W-1:0]             s_wr_data
);

  localparam int IW = $clog2(NUM_MASTERS);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_MASTERS - 1);

  arb_state_e             state_q, state_d;
  logic [IW-1:0]          owner_q, owner_d;
  logic [NUM_MASTERS-1:0] grnt_q, grnt_d;

  logic [IW-1:0] start_idx;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          arbitrate;

  // The search begins just past the current (or parked) owner, so the
  // owner itself is considered last.
  assign start_idx = (owner_q == LAST_IDX) ? '0 : owner_q + IW'(1);

  bus_rr_picker #(
    .N  (NUM_MASTERS),
    .IW (IW)
  ) u_picker (
    .req_n_i (m_req_),
    .start_i (start_idx),
    .found_o (pick_found),
    .index_o (pick_idx)
  );

  // Re-arbitrate when idle or when the owner has released. A low owner
  // request holds the bus unconditionally.
  assign arbitrate = (state_q == ARB_IDLE) || m_req_[owner_q];

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    if (arbitrate) begin
      if (pick_found) begin
        state_d = ARB_OWNED;
        owner_d = pick_idx;
      end else begin
        state_d = ARB_IDLE;
      end
    end
    grnt_d = '1;
    if (state_d == ARB_OWNED) begin
      grnt_d[owner_d] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ARB_IDLE;
      owner_q <= LAST_IDX;
      grnt_q  <= '1;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grnt_q  <= grnt_d;
    end
  end

  assign m_grnt_ = grnt_q;

  // Shared bus follows the owner combinationally. Non-owner strobes never
  // reach the bus, so an ungranted m_as_ has no effect.
  always_comb begin
    s_addr    = '0;
    s_as_     = BUS_IDLE_AS_;
    s_rw      = BUS_IDLE_RW;
    s_wr_data = '0;
    if (state_q == ARB_OWNED) begin
      s_addr    = m_addr[int'(owner_q)*ADDR_W +: ADDR_W];
      s_as_     = m_as_[owner_q];
      s_rw      = m_rw[owner_q];
      s_wr_data = m_wr_data[int'(owner_q)*DATA_W +: DATA_W];
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  import bus_pkg::*;

  localparam int NM = 4;
  localparam int AW = 30;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     m_req_;
  logic [NM-1:0]     m_grnt_;
  logic [NM*AW-1:0]  m_addr;
  logic [NM-1:0]     m_as_;
  logic [NM-1:0]     m_rw;
  logic [NM*DW-1:0]  m_wr_data;
  logic [AW-1:0]     s_addr;
  logic              s_as_;
  logic              s_rw;
  logic [DW-1:0]     s_wr_data;

  int checks   = 0;
  int failures = 0;

  // Reference model: who owns the bus, and whether anyone does.
  int mdl_owner;
  bit mdl_granted;

  always #5 clk = ~clk;

  bus_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .m_req_    (m_req_),
    .m_grnt_   (m_grnt_),
    .m_addr    (m_addr),
    .m_as_     (m_as_),
    .m_rw      (m_rw),
    .m_wr_data (m_wr_data),
    .s_addr    (s_addr),
    .s_as_     (s_as_),
    .s_rw      (s_rw),
    .s_wr_data (s_wr_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mdl_reset();
    mdl_owner   = NM - 1;
    mdl_granted = 1'b0;
  endtask

  // One rising edge of the arbitration rule: if idle or the owner let go,
  // walk the masters owner+1, owner+2, ... (mod NM) and take the first one
  // asking; nobody asking means idle with the owner left where it was.
  task automatic mdl_edge();
    int nxt;
    bit hit;
    if (!mdl_granted || m_req_[mdl_owner] == 1'b1) begin
      hit = 1'b0;
      nxt = mdl_owner;
      for (int k = 1; k <= NM; k++) begin
        if (!hit && m_req_[(mdl_owner + k) % NM] == 1'b0) begin
          hit = 1'b1;
          nxt = (mdl_owner + k) % NM;
        end
      end
      mdl_granted = hit;
      if (hit) mdl_owner = nxt;
    end
  endtask

  function automatic logic [NM-1:0] mdl_grant();
    logic [NM-1:0] g;
    g = '1;
    if (mdl_granted) g[mdl_owner] = 1'b0;
    return g;
  endfunction

  task automatic check_all(input string tag);
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic          eas, erw;
    if (mdl_granted) begin
      ea  = m_addr[mdl_owner*AW +: AW];
      ed  = m_wr_data[mdl_owner*DW +: DW];
      eas = m_as_[mdl_owner];
      erw = m_rw[mdl_owner];
    end else begin
      ea  = '0;
      ed  = '0;
      eas = DISABLE_;
      erw = READ;
    end
    chk({tag, "_grnt"}, 64'(m_grnt_), 64'(mdl_grant()));
    chk({tag, "_addr"}, 64'(s_addr), 64'(ea));
    chk({tag, "_as"}, 64'(s_as_), 64'(eas));
    chk({tag, "_rw"}, 64'(s_rw), 64'(erw));
    chk({tag, "_wdata"}, 64'(s_wr_data), 64'(ed));
  endtask

  // Inputs change only on falling edges; the model steps on the rising
  // edge with the same inputs the DUT samples; outputs are checked on the
  // next falling edge.
  task automatic cycle();
    @(posedge clk);
    if (rst) mdl_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst    = 1'b0;
    m_req_ = '1;
    m_as_  = '1;
    mdl_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int order[$];
    int seen;
    int cur;
    int held;

    rst       = 1'b1;
    m_req_    = '1;
    m_as_     = '1;
    m_rw      = '1;
    m_addr    = '0;
    m_wr_data = '0;
    mdl_reset();
    #1 rst = 1'b0;
    #1;
    chk("reset_grnt", 64'(m_grnt_), 64'(4'hF));
    chk("reset_as", 64'(s_as_), 64'(1'b1));
    check_all("reset");

    // Masters 0 and 2 request together; 0 first, then 2 with no gap.
    @(negedge clk);
    rst    = 1'b1;
    m_req_ = 4'b1010;
    cycle();
    chk("t1_grant0", 64'(m_grnt_), 64'(4'b1110));
    check_all("t1_a");
    m_req_ = 4'b1011;
    cycle();
    chk("t1_grant2", 64'(m_grnt_), 64'(4'b1011));
    check_all("t1_b");

    // All four request; each releases after 3 granted cycles and re-requests.
    do_reset();
    m_req_ = '0;
    seen   = -1;
    held   = 0;
    for (int c = 0; c < 40; c++) begin
      cycle();
      check_all("rot");
      cur = -1;
      for (int b = 0; b < NM; b++) if (m_grnt_[b] == 1'b0) cur = b;
      if (cur != seen) begin
        if (cur >= 0) order.push_back(cur);
        seen = cur;
        held = 1;
      end else begin
        held++;
      end
      m_req_ = '0;
      if (cur >= 0 && held == 3) m_req_[cur] = 1'b1;
    end
    chk("rot_count", 64'(order.size() >= 8), 64'(1));
    for (int i = 0; i < 8 && i < order.size(); i++) begin
      chk($sformatf("rot_order%0d", i), 64'(order[i]), 64'(i % NM));
    end

    // Master 1 holds for 20 cycles while master 3 waits.
    do_reset();
    m_req_ = 4'b1101;
    cycle();
    chk("t3_grant1", 64'(m_grnt_), 64'(4'b1101));
    m_req_ = 4'b0101;
    for (int c = 0; c < 20; c++) begin
      cycle();
      chk("t3_hold", 64'(m_grnt_), 64'(4'b1101));
      check_all("t3_hold");
    end
    m_req_ = 4'b0111;
    cycle();
    chk("t3_handover", 64'(m_grnt_), 64'(4'b0111));
    check_all("t3_handover");

    // Bus mux with master 2 owning; master 0 strobes without a grant.
    m_req_ = '1;
    cycle();
    check_all("t4_idle");
    m_req_ = 4'b1011;
    m_addr[2*AW +: AW]    = 30'h1234;
    m_rw[2]               = WRITE;
    m_wr_data[2*DW +: DW] = 32'hDEADBEEF;
    m_as_[2]              = 1'b0;
    cycle();
    chk("t4_grnt", 64'(m_grnt_), 64'(4'b1011));
    chk("t4_addr", 64'(s_addr), 64'(30'h1234));
    chk("t4_rw", 64'(s_rw), 64'(WRITE));
    chk("t4_wdata", 64'(s_wr_data), 64'(32'hDEADBEEF));
    chk("t4_as", 64'(s_as_), 64'(1'b0));
    m_as_[0]              = 1'b0;
    m_addr[0 +: AW]       = 30'h2AAA_AAAA;
    m_rw[0]               = READ;
    m_wr_data[0 +: DW]    = 32'h1111_1111;
    #1;
    chk("t4_rogue_addr", 64'(s_addr), 64'(30'h1234));
    chk("t4_rogue_rw", 64'(s_rw), 64'(WRITE));
    chk("t4_rogue_wdata", 64'(s_wr_data), 64'(32'hDEADBEEF));
    chk("t4_rogue_as", 64'(s_as_), 64'(1'b0));
    @(negedge clk);
    cycle();
    check_all("t4_rogue");

    // No requests: bus idle.
    m_req_ = '1;
    m_as_  = '1;
    cycle();
    cycle();
    chk("t5_grnt", 64'(m_grnt_), 64'(4'hF));
    chk("t5_as", 64'(s_as_), 64'(1'b1));
    chk("t5_addr", 64'(s_addr), 64'(0));
    chk("t5_rw", 64'(s_rw), 64'(READ));
    chk("t5_wdata", 64'(s_wr_data), 64'(0));

    // Reset mid-transfer while master 1 is granted.
    do_reset();
    m_req_   = 4'b1101;
    m_as_[1] = 1'b0;
    cycle();
    chk("t6_grant1", 64'(m_grnt_), 64'(4'b1101));
    chk("t6_as_low", 64'(s_as_), 64'(1'b0));
    #2 rst = 1'b0;
    #1;
    chk("t6_async_grnt", 64'(m_grnt_), 64'(4'hF));
    chk("t6_async_as", 64'(s_as_), 64'(1'b1));
    mdl_reset();
    m_req_ = 4'b1100;
    @(negedge clk);
    rst = 1'b1;
    cycle();
    chk("t6_master0_first", 64'(m_grnt_), 64'(4'b1110));
    check_all("t6_after");

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int b = 0; b < NM; b++) begin
        m_req_[b]              = ($urandom_range(0, 3) == 0);
        m_as_[b]               = $urandom_range(0, 1) == 1;
        m_rw[b]                = $urandom_range(0, 1) == 1;
        m_addr[b*AW +: AW]     = AW'($urandom());
        m_wr_data[b*DW +: DW]  = $urandom();
      end
      cycle();
      check_all("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
